par8_master: RTL

Host-side initiator for the 8-bit parallel bus whose FPGA end is the par8_receiver/par8_transmitter pair. It turns a simple per-byte command handshake into bus_clk/bus_rnw/bus_data cycles and synchronises the bus_done/bus_match status lines back into its own clock domain. It is used in loopback benches and in an FPGA-hosted driver that replaces the RPi as bus master.

---
 rtl/par8_pkg.sv | 17 +
 rtl/sync2.sv | 26 ++
 rtl/par8_master.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/par8_pkg.sv
// Shared constants for the par8 parallel bus: command opcodes, master FSM encoding
// and the default bus clock divider used by the master and the FPGA-side benches.
package par8_pkg;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int unsigned DefaultClkDiv = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StTurn = 2'd1;
    localparam state_t StLow  = 2'd2;
    localparam state_t StHigh = 2'd3;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous status inputs.
module sync2 #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/par8_master.sv
// Host-side initiator for the par8 bus: turns byte commands into bus_clk/bus_rnw/bus_data
// cycles and synchronises the FPGA's done/match status lines into the clk domain.
module par8_master
    import par8_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefaultClkDiv
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_op,
    input  logic [7:0] cmd_wdata,
    output logic       cmd_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       bus_clk,
    output logic       bus_rnw,
    output logic [7:0] bus_data_o,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_i,
    input  logic       bus_done,
    input  logic       bus_match,
    output logic       done_sync,
    output logic       match_sync
);

    localparam int unsigned     CntW    = $clog2(CLK_DIV + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(CLK_DIV - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rnw_q, rnw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            ready_q, ready_d;
    logic            bus_clk_q, bus_clk_d;
    logic            oe_q, oe_d;
    logic            accept;
    logic            phase_end;
    logic [1:0]      status_sync;

    assign accept    = cmd_valid && ready_q;
    assign phase_end = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = phase_end ? cnt_q : cnt_q - CntW'(1);
        rnw_d      = rnw_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = CntLoad;
                    if (cmd_op == OP_WRITE) begin
                        wdata_d = cmd_wdata;
                    end
                    // Direction flips only here, while bus_clk and oe are both low.
                    if (cmd_op != rnw_q) begin
                        rnw_d   = cmd_op;
                        state_d = StTurn;
                    end else begin
                        state_d = StLow;
                    end
                end
            end
            StTurn: begin
                if (phase_end) begin
                    state_d = StLow;
                    cnt_d   = CntLoad;
                end
            end
            StLow: begin
                if (phase_end) begin
                    state_d = StHigh;
                    cnt_d   = CntLoad;
                end
            end
            StHigh: begin
                if (phase_end) begin
                    state_d = StIdle;
                    if (rnw_q == OP_READ) begin
                        rd_data_d  = bus_data_i;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin-facing strobes are registered from the next state so they never glitch.
    always_comb begin
        ready_d   = (state_d == StIdle);
        bus_clk_d = (state_d == StHigh);
        oe_d      = ((state_d == StLow) || (state_d == StHigh)) && (rnw_d == OP_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rnw_q      <= OP_WRITE;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            bus_clk_q  <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            bus_clk_q  <= bus_clk_d;
            oe_q       <= oe_d;
        end
    end

    sync2 #(
        .Width (2)
    ) u_status_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({bus_done, bus_match}),
        .q_o   (status_sync)
    );

    assign cmd_ready   = ready_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign bus_clk     = bus_clk_q;
    assign bus_rnw     = rnw_q;
    assign bus_data_o  = wdata_q;
    assign bus_data_oe = oe_q;
    assign done_sync   = status_sync[1];
    assign match_sync  = status_sync[0];

endmodule
